// File: rtl/adc_deser_pkg.sv
// Shared types and helpers for the aligned multi-channel ADC deserializer.
package adc_deser_pkg;

    localparam int ERRCNT_W = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } deser_state_t;

    // Frame pattern with the upper half of the word ones and the lower half zeros.
    function automatic logic [15:0] default_frm_pat(input int bits);
        logic [15:0] pat;
        pat = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if ((i >= bits / 2) && (i < bits)) begin
                pat[i] = 1'b1;
            end else begin
                pat[i] = 1'b0;
            end
        end
        return pat;
    endfunction

    function automatic logic [15:0] bitrev(input logic [15:0] word, input int bits);
        logic [15:0] rev;
        rev = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < bits) begin
                rev[i] = word[bits - 1 - i];
            end else begin
                rev[i] = 1'b0;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/adc_deser_lane.sv
// One serial data channel: shift register, bit-order handling and parallel output register.
module adc_deser_lane
    import adc_deser_pkg::*;
#(
    parameter int BITS      = 12,
    parameter int MSB_FIRST = 1
) (
    input  logic            d_clk,
    input  logic            rst_n,
    input  logic            ser_in,
    input  logic            load,
    output logic [BITS-1:0] dat
);

    logic [BITS-2:0] shift_r;
    logic [BITS-1:0] raw_s;
    logic [BITS-1:0] word_s;
    logic [BITS-1:0] dat_r;

    // Earliest received bit ends up in the MSB of raw_s.
    assign raw_s  = {shift_r, ser_in};
    assign word_s = (MSB_FIRST != 0) ? raw_s : BITS'(bitrev(16'(raw_s), BITS));
    assign dat    = dat_r;

    // Serial capture shifts every cycle; the output word only updates on load.
    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {(BITS-1){1'b0}};
            dat_r   <= {BITS{1'b0}};
        end else begin
            shift_r <= raw_s[BITS-2:0];
            if (load) begin
                dat_r <= word_s;
            end else begin
                dat_r <= dat_r;
            end
        end
    end

endmodule

// File: rtl/adc_deser_aligned.sv
// Multi-channel serial ADC deserializer with frame-based word alignment (bit slip, lock/unlock).
// Optional mismatch counter enabled by defining ADC_DESER_ERRCNT_EN; otherwise err_cnt is tied to 0.
module adc_deser_aligned
    import adc_deser_pkg::*;
#(
    parameter int              N_CH       = 4,
    parameter int              BITS       = 12,
    parameter int              MSB_FIRST  = 1,
    parameter logic [BITS-1:0] FRM_PAT    = BITS'(default_frm_pat(BITS)),
    parameter int              LOCK_CNT   = 4,
    parameter int              UNLOCK_CNT = 2
) (
    input  logic                     d_clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ser_dat,
    input  logic                     ser_frm,
    input  logic                     align_req,
    output logic [N_CH*BITS-1:0]     dat,
    output logic                     dat_valid,
    output logic                     locked,
    output logic [$clog2(BITS)-1:0]  slip_cnt,
    output logic [ERRCNT_W-1:0]      err_cnt
);

    localparam int CNT_W = $clog2(BITS);

    deser_state_t    state_r;
    deser_state_t    state_s;
    logic [CNT_W-1:0] bcnt_r;
    logic            slip_hold_r;
    logic [3:0]      mcnt_r;
    logic [3:0]      mcnt_s;
    logic [3:0]      ucnt_r;
    logic [3:0]      ucnt_s;
    logic [BITS-2:0] frm_shift_r;
    logic [BITS-1:0] frm_raw_s;
    logic [BITS-1:0] frm_word_s;
    logic            boundary_s;
    logic            match_s;
    logic            slip_s;
    logic            load_s;
    logic            dat_valid_r;
    logic            locked_r;
    logic [CNT_W-1:0] slip_cnt_r;

    assign frm_raw_s  = {frm_shift_r, ser_frm};
    assign frm_word_s = (MSB_FIRST != 0) ? frm_raw_s : BITS'(bitrev(16'(frm_raw_s), BITS));
    assign boundary_s = (bcnt_r == CNT_W'(BITS - 1));
    assign match_s    = (frm_word_s == FRM_PAT);

    // Frame shift register and bit counter; a slip holds the counter at zero one extra cycle.
    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_shift_r <= {(BITS-1){1'b0}};
            bcnt_r      <= {CNT_W{1'b0}};
            slip_hold_r <= 1'b0;
        end else begin
            frm_shift_r <= frm_raw_s[BITS-2:0];
            if (slip_hold_r) begin
                bcnt_r      <= {CNT_W{1'b0}};
                slip_hold_r <= 1'b0;
            end else if (boundary_s) begin
                bcnt_r      <= {CNT_W{1'b0}};
                slip_hold_r <= slip_s;
            end else begin
                bcnt_r      <= bcnt_r + CNT_W'(1);
                slip_hold_r <= 1'b0;
            end
        end
    end

    // Alignment FSM next state; align_req overrides anything happening at a boundary.
    always_comb begin
        state_s = state_r;
        mcnt_s  = mcnt_r;
        ucnt_s  = ucnt_r;
        slip_s  = 1'b0;
        load_s  = 1'b0;
        if (align_req) begin
            state_s = HUNT;
            mcnt_s  = 4'd0;
            ucnt_s  = 4'd0;
        end else if (boundary_s) begin
            case (state_r)
                HUNT: begin
                    if (match_s) begin
                        mcnt_s  = 4'd1;
                        state_s = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end else begin
                        slip_s = 1'b1;
                    end
                end
                VERIFY: begin
                    if (match_s) begin
                        mcnt_s = mcnt_r + 4'd1;
                        if (mcnt_s >= 4'(LOCK_CNT)) begin
                            state_s = LOCKED;
                            ucnt_s  = 4'd0;
                        end else begin
                            state_s = VERIFY;
                        end
                    end else begin
                        slip_s  = 1'b1;
                        mcnt_s  = 4'd0;
                        state_s = HUNT;
                    end
                end
                LOCKED: begin
                    load_s = 1'b1;
                    if (match_s) begin
                        ucnt_s = 4'd0;
                    end else if ((ucnt_r + 4'd1) >= 4'(UNLOCK_CNT)) begin
                        state_s = HUNT;
                        ucnt_s  = 4'd0;
                        mcnt_s  = 4'd0;
                    end else begin
                        ucnt_s = ucnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s = HUNT;
                    mcnt_s  = 4'd0;
                    ucnt_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, match counters and registered status outputs.
    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            mcnt_r      <= 4'd0;
            ucnt_r      <= 4'd0;
            dat_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            slip_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            mcnt_r      <= mcnt_s;
            ucnt_r      <= ucnt_s;
            dat_valid_r <= load_s;
            locked_r    <= (state_s == LOCKED);
            if (align_req) begin
                slip_cnt_r <= {CNT_W{1'b0}};
            end else if (slip_s) begin
                slip_cnt_r <= (slip_cnt_r == CNT_W'(BITS - 1)) ? {CNT_W{1'b0}}
                                                                : slip_cnt_r + CNT_W'(1);
            end else begin
                slip_cnt_r <= slip_cnt_r;
            end
        end
    end

`ifdef ADC_DESER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_r;
    logic                err_inc_s;

    assign err_inc_s = boundary_s && !align_req && (state_r == LOCKED) && !match_s;

    // Saturating count of frame mismatches seen while locked.
    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (err_inc_s && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = {ERRCNT_W{1'b0}};
`endif

    assign dat_valid = dat_valid_r;
    assign locked    = locked_r;
    assign slip_cnt  = slip_cnt_r;

    genvar k;
    for (k = 0; k < N_CH; k++) begin : g_lane
        adc_deser_lane #(
            .BITS      (BITS),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .d_clk  (d_clk),
            .rst_n  (rst_n),
            .ser_in (ser_dat[k]),
            .load   (load_s),
            .dat    (dat[k*BITS +: BITS])
        );
    end

endmodule

// File: doc/adc_deser_aligned.md
Name: adc_deser_aligned

Overview:
Parametrised multi-channel serial ADC deserializer with automatic word alignment. All channels and the ADC frame line are sampled on the bit clock. The block hunts for the expected frame pattern by bit-slipping, locks after repeated matches, and then emits parallel words for every channel with a one-cycle valid pulse. It sits directly behind the ADC LVDS inputs and feeds the pattern/capture logic downstream.

Parameters:
N_CH, 4, number of serial data channels
BITS, 12, bits per sample word (even, 4..16)
MSB_FIRST, 1, 1 = first serial bit of a word is the MSB; 0 = LSB first
FRM_PAT, {BITS/2 ones, BITS/2 zeros}, expected frame-line word, in the same bit order as the data
LOCK_CNT, 4, consecutive frame matches required to enter LOCKED (1..15)
UNLOCK_CNT, 2, consecutive frame mismatches in LOCKED that return to HUNT (1..15)

Ports:
d_clk  in  1  bit clock; the only clock; all logic on its rising edge
rst_n  in  1  asynchronous, active-low reset
ser_dat  in  N_CH  serial data, one bit per channel per d_clk
ser_frm  in  1  serial frame line, sampled like the data
align_req  in  1  level/pulse; forces re-alignment (go to HUNT)
dat  out  N_CH*BITS  parallel words; channel k occupies [k*BITS +: BITS]
dat_valid  out  1  one-cycle pulse: new words on dat
locked  out  1  high in LOCKED state
slip_cnt  out  $clog2(BITS)  total bit slips since the last reset/align_req, modulo BITS
err_cnt  out  16  frame mismatches seen while LOCKED (see Optional Feature)

Behaviour:
- Reset: all shift registers, dat, dat_valid, locked, slip_cnt, err_cnt, bit counter and match counters go to 0. The FSM goes to HUNT. Reset mid-word discards the partial word.
- Per-channel and frame shift registers shift every cycle. Bit counter bcnt runs 0..BITS-1 and wraps.
- Boundary cycle: bcnt == BITS-1. The word is the BITS-1 stored bits plus the current input bit. The frame word is compared to FRM_PAT combinationally in that cycle.
- HUNT:
  - Boundary with match: mcnt <= 1, go to VERIFY; if LOCK_CNT == 1, go directly to LOCKED.
  - Boundary with mismatch: slip. bcnt stays 0 for one extra cycle, so the next boundary comes BITS+1 cycles later. slip_cnt increments and wraps at BITS.
- VERIFY:
  - Boundary with match: mcnt increments; when mcnt reaches LOCK_CNT, go to LOCKED.
  - Boundary with mismatch: slip as in HUNT, mcnt <= 0, go to HUNT.
- LOCKED:
  - Every boundary: dat <= word, dat_valid = 1 on the next cycle. Latency is 1 cycle from the last bit sampled to dat valid.
  - Mismatch: err_cnt increments, ucnt increments, and the word is still output.
  - Match: ucnt <= 0.
  - ucnt reaching UNLOCK_CNT: go to HUNT, locked deasserts the following cycle, no slip.
- dat holds its last value outside LOCKED; dat_valid is 0 outside LOCKED.
- align_req == 1: next state is HUNT; mcnt, ucnt and slip_cnt clear; locked = 0 next cycle. align_req wins over a simultaneous boundary. err_cnt is not cleared.
- MSB_FIRST = 0: words are bit-reversed before compare and output, so FRM_PAT is always written in MSB..LSB order.
- err_cnt saturates at 16'hFFFF.

Optional Feature:
ADC_DESER_ERRCNT_EN.
- Defined: err_cnt counts as specified.
- Undefined: the counter logic is removed and err_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Package adc_deser_pkg holds:
  - FSM state enum (HUNT, VERIFY, LOCKED)
  - function default_frm_pat(BITS)
  - function bitrev(word)
  - ERRCNT_W = 16
- One sub-module, adc_deser_lane: per-channel shift register, bit-order handling and output register, generated N_CH times. The top holds bcnt, the frame lane and the FSM.

Test Plan:
- Frame aligned from reset (BITS=12, N_CH=4, ch k sends 12'hA50+k): locked after the 4th boundary (cycle 48); then dat_valid every 12 cycles; dat = {12'hA53, 12'hA52, 12'hA51, 12'hA50}.
- Frame offset by 5 bits: exactly 5 slips (slip_cnt = 5), then lock; words correct with no extra slips.
- While LOCKED, corrupt one frame word: err_cnt = 1, locked stays 1. Corrupt 2 consecutive words: locked drops; slips resume only on later mismatches.
- align_req pulse on a boundary cycle while LOCKED: no dat_valid that cycle; locked = 0; slip_cnt = 0; relock after 4 matches.
- rst_n low mid-word: all outputs 0 immediately (asynchronous). After release, realignment from HUNT gives correct data.
- MSB_FIRST=0, BITS=8 with LSB-first stimulus 8'h3C: dat = 8'h3C. With ADC_DESER_ERRCNT_EN undefined and corrupted frames, err_cnt stays 0.
